contador_multicanal: RTL and testbench

- Parametrised successor to the transaction-layer per-FIFO word counter.
- Keeps one counter per channel. A channel's counter increments on each increment strobe, which the parent asserts when that channel's FIFO pops valid data.
- The requester reads a selected channel's count through a req/idx handshake, gated by the main FSM being in IDLE.
- Adds behaviour the previous counter lacks: N channels, arbitrary count width, optional read-and-clear, sticky per-channel overflow flags, and optional saturation.

---
 rtl/contador_multicanal.sv | 128 ++++++++++++
 tb/tb_contador_multicanal.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_multicanal.sv
// contador_multicanal: per-channel word counter with a req/idx read port.
//
// One CNT_W-bit counter per channel, bumped by its inc strobe every cycle
// regardless of the main FSM state. A read request is honoured only while
// state == IDLE_CODE and idx names an existing channel. The result appears
// one cycle later on data_out, and valid is high for that one cycle.
// rd_clr on an accepted read clears the selected counter without losing a
// same-cycle increment. ovf holds a sticky per-channel overflow flag.
//
// Optional build macro CONTADOR_SATURATE_EN: when defined, counters saturate
// at the maximum value instead of wrapping. ovf is still set.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_L   in   synchronous active-low reset
//   state     in   [3:0] main FSM state
//   inc       in   [NUM_CH-1:0] per-channel increment strobe
//   req       in   read request
//   idx       in   [IDX_W-1:0] channel selected by req
//   rd_clr    in   clear selected counter after reading it
//   data_out  out  [CNT_W-1:0] count from the last accepted request
//   valid     out  data_out is fresh this cycle
//   ovf       out  [NUM_CH-1:0] sticky overflow flags

module contador_multicanal #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned IDX_W     = 2,
    parameter logic [3:0]  IDLE_CODE = 4'b0100
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [3:0]        state,
    input  logic [NUM_CH-1:0] inc,
    input  logic              req,
    input  logic [IDX_W-1:0]  idx,
    input  logic              rd_clr,
    output logic [CNT_W-1:0]  data_out,
    output logic              valid,
    output logic [NUM_CH-1:0] ovf
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [CNT_W-1:0]  data_out_q, data_out_d;
    logic              valid_q, valid_d;

    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] ovf_evt;
    logic              idx_in_range;
    logic              accept;
    logic [CNT_W-1:0]  rd_val;

    // Decode idx by comparison so an out-of-range idx selects nothing.
    always_comb begin
        sel          = '0;
        idx_in_range = 1'b0;
        rd_val       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) begin
                sel[i]       = 1'b1;
                idx_in_range = 1'b1;
                rd_val       = cnt_q[i];
            end
        end
    end

    assign accept = req && (state == IDLE_CODE) && idx_in_range;

    always_comb begin
        ovf_evt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ovf_evt[i] = inc[i] && (cnt_q[i] == CntMax);
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        data_out_d = data_out_q;
        valid_d    = accept;
        if (accept) begin
            data_out_d = rd_val;
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (accept && rd_clr && sel[i]) begin
                // Clear keeps a same-cycle increment; overflow of this cycle still flags.
                cnt_d[i] = CNT_W'(inc[i]);
                ovf_d[i] = ovf_evt[i];
            end else begin
                if (inc[i]) begin
`ifdef CONTADOR_SATURATE_EN
                    if (cnt_q[i] != CntMax) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
`else
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
`endif
                end
                ovf_d[i] = ovf_q[i] | ovf_evt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_contador_multicanal.sv
module tb_contador_multicanal;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 5;
    localparam int IDX_W  = 2;
    localparam logic [3:0] IDLE = 4'b0100;
    localparam int MAXV = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_L;
    logic [3:0]        state;
    logic [NUM_CH-1:0] inc;
    logic              req;
    logic [IDX_W-1:0]  idx;
    logic              rd_clr;
    logic [CNT_W-1:0]  data_out;
    logic              valid;
    logic [NUM_CH-1:0] ovf;

    // Second instance with fewer channels than idx can address.
    logic              req3;
    logic [IDX_W-1:0]  idx3;
    logic [2:0]        inc3;
    logic [CNT_W-1:0]  data_out3;
    logic              valid3;
    logic [2:0]        ovf3;

    contador_multicanal #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W), .IDLE_CODE(IDLE)
    ) dut (
        .clk(clk), .reset_L(reset_L), .state(state), .inc(inc), .req(req),
        .idx(idx), .rd_clr(rd_clr), .data_out(data_out), .valid(valid), .ovf(ovf)
    );

    contador_multicanal #(
        .NUM_CH(3), .CNT_W(CNT_W), .IDX_W(IDX_W), .IDLE_CODE(IDLE)
    ) dut3 (
        .clk(clk), .reset_L(reset_L), .state(IDLE), .inc(inc3), .req(req3),
        .idx(idx3), .rd_clr(1'b0), .data_out(data_out3), .valid(valid3), .ovf(ovf3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain integer counts per channel.
    int m_cnt [NUM_CH];
    bit m_ovf [NUM_CH];
    int m_data;
    bit m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int bump(input int v);
`ifdef CONTADOR_SATURATE_EN
        return (v == MAXV) ? MAXV : v + 1;
`else
        return (v + 1) % (MAXV + 1);
`endif
    endfunction

    task automatic model_step();
        bit acc;
        bit over;
        if (!reset_L) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_cnt[c] = 0;
                m_ovf[c] = 0;
            end
            m_data  = 0;
            m_valid = 0;
            return;
        end
        acc = req && (state == IDLE) && (int'(idx) < NUM_CH);
        m_valid = acc;
        if (acc) m_data = m_cnt[idx];
        for (int c = 0; c < NUM_CH; c++) begin
            over = inc[c] && (m_cnt[c] == MAXV);
            if (acc && rd_clr && c == int'(idx)) begin
                m_cnt[c] = inc[c] ? 1 : 0;
                m_ovf[c] = over;
            end else begin
                if (inc[c]) m_cnt[c] = bump(m_cnt[c]);
                if (over) m_ovf[c] = 1;
            end
        end
    endtask

    task automatic tick();
        logic [NUM_CH-1:0] exp_ovf;
        @(posedge clk);
        model_step();
        #1;
        exp_ovf = '0;
        for (int c = 0; c < NUM_CH; c++) exp_ovf[c] = m_ovf[c];
        check("valid", 32'(valid), 32'(m_valid));
        check("data_out", 32'(data_out), 32'(m_data));
        check("ovf", 32'(ovf), 32'(exp_ovf));
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] mask, input int n);
        inc = mask;
        for (int k = 0; k < n; k++) tick();
        inc = '0;
    endtask

    task automatic read(input int ch, input bit clr);
        req    = 1'b1;
        idx    = IDX_W'(ch);
        rd_clr = clr;
        tick();
        req    = 1'b0;
        rd_clr = 1'b0;
    endtask

    initial begin
        reset_L = 1'b0;
        state   = IDLE;
        inc     = '0;
        req     = 1'b0;
        idx     = '0;
        rd_clr  = 1'b0;
        req3    = 1'b0;
        idx3    = '0;
        inc3    = '0;

        // Reset then counting
        do_reset();
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data", 32'(data_out), 32'd0);
        pulse(4'b0001, 3);
        pulse(4'b0100, 7);
        read(0, 0);
        check("t1_rd0_data", 32'(data_out), 32'd3);
        check("t1_rd0_valid", 32'(valid), 32'd1);
        read(2, 0);
        check("t1_rd2_data", 32'(data_out), 32'd7);
        check("t1_ovf", 32'(ovf), 32'd0);

        // State gating: rejected read keeps data_out
        state = 4'b1000;
        read(1, 0);
        check("t2_gate_valid", 32'(valid), 32'd0);
        check("t2_gate_data", 32'(data_out), 32'd7);
        state = IDLE;

        // Out-of-range idx on the 3-channel instance
        req3 = 1'b1;
        idx3 = 2'd3;
        @(posedge clk); #1;
        check("t2_oor_valid", 32'(valid3), 32'd0);
        idx3 = 2'd2;
        @(posedge clk); #1;
        check("t2_inrange_valid", 32'(valid3), 32'd1);
        check("t2_inrange_data", 32'(data_out3), 32'd0);
        req3 = 1'b0;
        @(posedge clk); #1;
        check("t2_valid_pulse", 32'(valid3), 32'd0);

        // Same-cycle read-clear and increment
        do_reset();
        pulse(4'b0010, 9);
        inc = 4'b0010;
        read(1, 1);
        inc = '0;
        check("t3_clr_data", 32'(data_out), 32'd9);
        tick();
        read(1, 0);
        check("t3_after_clr", 32'(data_out), 32'd1);

        // Overflow on channel 3
        do_reset();
        pulse(4'b1000, 32);
        check("t4_ovf_set", 32'(ovf[3]), 32'd1);
        pulse(4'b1000, 1);
        read(3, 0);
`ifdef CONTADOR_SATURATE_EN
        check("t4_rd", 32'(data_out), 32'd31);
`else
        check("t4_rd", 32'(data_out), 32'd1);
`endif
        read(3, 1);
        check("t4_ovf_clr", 32'(ovf[3]), 32'd0);

        // Overflow on channel 0 with 40 pulses
        do_reset();
        pulse(4'b0001, 40);
        read(0, 0);
`ifdef CONTADOR_SATURATE_EN
        check("t5_rd", 32'(data_out), 32'd31);
`else
        check("t5_rd", 32'(data_out), 32'd8);
`endif
        check("t5_ovf", 32'(ovf[0]), 32'd1);
        read(0, 1);
        read(0, 0);
        check("t5_after_clr", 32'(data_out), 32'd0);
        check("t5_ovf_clr", 32'(ovf[0]), 32'd0);

        // Reset mid-operation discards pending result
        pulse(4'b1111, 5);
        req = 1'b1;
        idx = 2'd1;
        reset_L = 1'b0;
        tick();
        check("t6_rst_valid", 32'(valid), 32'd0);
        check("t6_rst_data", 32'(data_out), 32'd0);
        reset_L = 1'b1;
        req = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            read(c, 0);
            check("t6_cnt_zero", 32'(data_out), 32'd0);
        end

        // Random traffic with continuous requests
        for (int k = 0; k < 600; k++) begin
            reset_L = ($urandom_range(0, 79) != 0);
            state   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : IDLE;
            inc     = NUM_CH'($urandom);
            req     = 1'b1;
            idx     = IDX_W'($urandom_range(0, NUM_CH - 1));
            rd_clr  = (k < 300) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 3) == 0);
            tick();
        end
        req    = 1'b0;
        rd_clr = 1'b0;
        inc    = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
